// File: rtl/gpr_dump_reader.sv
// Walks every GPR through one combinational regfile read port and streams
// (index, value) records out over a valid/ready handshake.
module gpr_dump_reader #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state,    w_state_n;
  logic [ADDR_W-1:0] r_idx,      w_idx_n;
  logic [ADDR_W-1:0] r_out_idx,  w_out_idx_n;
  logic [DATA_W-1:0] r_out_data, w_out_data_n;
  logic              r_out_valid, w_out_valid_n;
  logic              r_out_last,  w_out_last_n;
  logic              r_busy,      w_busy_n;
  logic              r_done,      w_done_n;
  logic              w_skip;

  // A zero-valued register is skipped only when enabled and not the final index
  assign w_skip = (SKIP_ZERO != 0) && (rf_data == '0) && (r_idx != LAST_IDX);

  // Next-state and next-output logic; flags derive from the state being entered
  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_out_idx_n  = r_out_idx;
    w_out_data_n = r_out_data;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_READ;
          w_idx_n   = '0;
        end
      end
      S_READ: begin
        w_out_idx_n  = r_idx;
        w_out_data_n = rf_data;
        if (w_skip) begin
          w_idx_n = r_idx + ADDR_W'(1);
        end else begin
          w_state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_n = S_DONE;
          end else begin
            w_idx_n   = r_idx + ADDR_W'(1);
            w_state_n = S_READ;
          end
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        w_idx_n   = '0;
      end
      default: begin
        w_state_n = S_IDLE;
        w_idx_n   = '0;
      end
    endcase
    w_out_valid_n = (w_state_n == S_HOLD);
    w_out_last_n  = (w_state_n == S_HOLD) && (w_out_idx_n == LAST_IDX);
    w_busy_n      = (w_state_n == S_READ) || (w_state_n == S_HOLD);
    w_done_n      = (w_state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_out_idx   <= w_out_idx_n;
      r_out_data  <= w_out_data_n;
      r_out_valid <= w_out_valid_n;
      r_out_last  <= w_out_last_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
    end
  end

  // The walk index is a register and is held at zero whenever idle
  assign rf_addr   = r_idx;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Bench for gpr_dump_reader: scenario table plus randomized dumps, each checked
// against a record list derived from a snapshot of the bench-owned register file.
module tb_gpr_dump_reader;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, st, rdy, sel;
  logic [DW-1:0] gpr [NR];

  logic          start0, start1, ready0, ready1;
  logic [AW-1:0] rf_addr0, rf_addr1, idx0, idx1;
  logic [DW-1:0] rf_data0, rf_data1, data0, data1;
  logic          valid0, valid1, last0, last1, busy0, busy1, done0, done1;

  assign rf_data0 = gpr[rf_addr0];
  assign rf_data1 = gpr[rf_addr1];
  assign start0   = st & ~sel;
  assign start1   = st & sel;
  assign ready0   = rdy & ~sel;
  assign ready1   = rdy & sel;

  gpr_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .rf_addr(rf_addr0), .rf_data(rf_data0),
    .out_valid(valid0), .out_ready(ready0), .out_idx(idx0), .out_data(data0),
    .out_last(last0), .busy(busy0), .done(done0));

  gpr_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rf_addr(rf_addr1), .rf_data(rf_data1),
    .out_valid(valid1), .out_ready(ready1), .out_idx(idx1), .out_data(data1),
    .out_last(last1), .busy(busy1), .done(done1));

  logic          valid, last, busy, done;
  logic [AW-1:0] idx, rf_addr;
  logic [DW-1:0] data;
  assign valid   = sel ? valid1   : valid0;
  assign last    = sel ? last1    : last0;
  assign busy    = sel ? busy1    : busy0;
  assign done    = sel ? done1    : done0;
  assign idx     = sel ? idx1     : idx0;
  assign rf_addr = sel ? rf_addr1 : rf_addr0;
  assign data    = sel ? data1    : data0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rf_addr"}, 32'(rf_addr), 32'h0);
    chk({tag, "_out_idx"}, 32'(idx), 32'h0);
    chk({tag, "_out_data"}, data, 32'h0);
    chk({tag, "_out_valid"}, 32'(valid), 32'h0);
    chk({tag, "_out_last"}, 32'(last), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // 0: GPR k = 0x1000_0000+k, 1: only GPR4/GPR29 nonzero, 2: random sparse
  task automatic fill(input int mode);
    for (int k = 0; k < NR; k++) begin
      case (mode)
        0:       gpr[k] = (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
        1:       gpr[k] = (k == 4) ? 32'hDEAD_BEEF : ((k == 29) ? 32'h0000_3000 : 32'h0);
        default: gpr[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
      endcase
    end
  endtask

  // Runs one dump; cycle c counts edges after the edge that sampled start.
  // Reference: record k is captured at edge 2k+1 when the consumer never stalls.
  task automatic run_dump(input bit s, input int rmode, input int stall_idx, input int stall_len,
                          input bit xstart, input int wr_edge, input int wr_idx,
                          input logic [31:0] wr_data, input int abort,
                          output int nrec, output int dcyc, output logic [31:0] d9);
    logic [31:0] snap [NR];
    int          qi[$];
    logic [31:0] qd[$];
    int          nexp, ndone, stall_cnt;
    bit          phold, r, finished;
    logic [AW-1:0] pidx;
    logic [31:0] pdat;
    nrec = 0; dcyc = -1; d9 = 32'hx; ndone = 0; stall_cnt = 0; phold = 1'b0; finished = 1'b0;
    pidx = '0; pdat = '0;
    sel = s;
    for (int k = 0; k < NR; k++) begin
      snap[k] = gpr[k];
      if (wr_edge >= 0 && k == wr_idx && wr_edge < 2 * k + 1) snap[k] = wr_data;
    end
    for (int k = 0; k < NR; k++) begin
      if (!s || snap[k] != 0 || k == NR - 1) begin
        qi.push_back(k);
        qd.push_back(snap[k]);
      end
    end
    nexp = qi.size();
    rdy = 1'b0;
    @(posedge clk); #1;
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0 && c == wr_edge) gpr[wr_idx] = wr_data;
      if (done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c;
          chk("busy_in_done", 32'(busy), 32'h0);
          chk("valid_in_done", 32'(valid), 32'h0);
        end
      end else if (dcyc < 0) begin
        chk("busy_during_dump", 32'(busy), 32'h1);
      end
      if (phold) begin
        chk("hold_valid", 32'(valid), 32'h1);
        chk("hold_idx", 32'(idx), 32'(pidx));
        chk("hold_data", data, pdat);
      end
      if (valid) chk("out_last", 32'(last), 32'(idx == AW'(NR - 1)));
      if (abort >= 0 && valid && idx == AW'(abort)) begin
        rdy = 1'b0; st = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("abort_reset");
        return;
      end
      if (rmode == 1) begin
        r = ($urandom_range(0, 1) == 1);
      end else if (rmode == 2 && valid && idx == AW'(stall_idx) && stall_cnt < stall_len) begin
        r = 1'b0;
        stall_cnt++;
      end else begin
        r = 1'b1;
      end
      rdy = r;
      if (valid && r) begin
        if (qi.size() == 0) begin
          chk("extra_record", 32'(idx), 32'hFFFF_FFFF);
        end else begin
          chk("rec_idx", 32'(idx), 32'(qi[0]));
          chk("rec_data", data, qd[0]);
          void'(qi.pop_front());
          void'(qd.pop_front());
        end
        if (idx == AW'(9)) d9 = data;
        nrec++;
      end
      phold = valid && !r;
      pidx  = idx;
      pdat  = data;
      st = xstart && (c == 3 || c == 20 || (dcyc >= 0 && c == dcyc));
      if (dcyc >= 0 && c == dcyc + 1) chk("rf_addr_idle", 32'(rf_addr), 32'h0);
      if (dcyc >= 0 && c == dcyc + 3) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    st = 1'b0; rdy = 1'b0;
    chk("dump_finished", 32'(finished), 32'h1);
    chk("nrec_vs_model", 32'(nrec), 32'(nexp));
    chk("done_pulses", 32'(ndone), 32'h1);
    chk("busy_after", 32'(busy), 32'h0);
    if (rmode == 2) chk("stall_cycles", 32'(stall_cnt), 32'(stall_len));
  endtask

  typedef struct {
    bit          skip;
    int          fill, rmode, stall_idx, stall_len;
    bit          xstart;
    int          wr_edge, wr_idx;
    logic [31:0] wr_data;
    int          abort, exp_nrec, exp_dcyc;
    bit          chk9;
    logic [31:0] exp9;
  } vec_t;

  vec_t        vt [8];
  int          nrec, dcyc;
  logic [31:0] d9;

  initial begin
    vt[0] = '{0, 0, 0, -1, 0, 0, -1, 0, 32'h0, -1, 32, 64, 1, 32'h1000_0009};
    vt[1] = '{0, 0, 2,  7, 5, 0, -1, 0, 32'h0, -1, 32, 69, 0, 32'h0};
    vt[2] = '{1, 1, 0, -1, 0, 0, -1, 0, 32'h0, -1,  3, 35, 0, 32'h0};
    vt[3] = '{0, 0, 0, -1, 0, 1, -1, 0, 32'h0, -1, 32, 64, 0, 32'h0};
    vt[4] = '{0, 0, 0, -1, 0, 0, 19, 9, 32'hFFFF_FFFF, -1, 32, 64, 1, 32'h1000_0009};
    vt[5] = '{0, 0, 0, -1, 0, 0, 18, 9, 32'hFFFF_FFFF, -1, 32, 64, 1, 32'hFFFF_FFFF};
    vt[6] = '{0, 0, 0, -1, 0, 0, -1, 0, 32'h0, 12, 12, -1, 0, 32'h0};
    vt[7] = '{0, 0, 0, -1, 0, 0, -1, 0, 32'h0, -1, 32, 64, 1, 32'h1000_0009};

    reset = 1'b1; st = 1'b0; rdy = 1'b0; sel = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init0");
    sel = 1'b1;
    #1;
    check_reset_outputs("init1");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fill(vt[i].fill);
      run_dump(vt[i].skip, vt[i].rmode, vt[i].stall_idx, vt[i].stall_len, vt[i].xstart,
               vt[i].wr_edge, vt[i].wr_idx, vt[i].wr_data, vt[i].abort, nrec, dcyc, d9);
      chk($sformatf("v%0d_nrec", i), 32'(nrec), 32'(vt[i].exp_nrec));
      if (vt[i].exp_dcyc >= 0) chk($sformatf("v%0d_done_cycle", i), 32'(dcyc), 32'(vt[i].exp_dcyc));
      if (vt[i].chk9) chk($sformatf("v%0d_rec9", i), d9, vt[i].exp9);
    end

    for (int t = 0; t < 6; t++) begin
      fill(2);
      run_dump(t[0], 1, -1, 0, 1'b0, -1, 0, 32'h0, -1, nrec, dcyc, d9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
